// File: rtl/edge_bit_packer_if.sv
// Bus bundle for edge_bit_packer.
//   pixel_in/pixel_valid : edge-magnitude stream from the convolution (no backpressure)
//   out_byte/out_valid/out_ready : packed edge-bit bytes, valid/ready handshake
//   out_sof/out_eol/out_eof      : frame markers travelling with the head byte
//   overflow                     : sticky drop indicator
// master = the packer (drives the output stream); slave = its environment.
interface edge_bit_packer_if #(
  parameter int WORD_SIZE = 8
);
  logic [WORD_SIZE-1:0] pixel_in;
  logic                 pixel_valid;
  logic [7:0]           out_byte;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sof;
  logic                 out_eol;
  logic                 out_eof;
  logic                 overflow;

  modport master (
    input  pixel_in, pixel_valid, out_ready,
    output out_byte, out_valid, out_sof, out_eol, out_eof, overflow
  );

  modport slave (
    output pixel_in, pixel_valid, out_ready,
    input  out_byte, out_valid, out_sof, out_eol, out_eof, overflow
  );
endinterface

// File: rtl/edge_bit_packer.sv
// edge_bit_packer: binarizes the Laplacian edge-magnitude stream against
// THRESHOLD, packs the bits 8 per byte (column c -> bit c mod 8) row by row
// over the OUT_COLS x OUT_ROWS valid image, and queues bytes with sof/eol/eof
// markers in a small FIFO.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset
//   bus  : edge_bit_packer_if.master (pixel input, byte output, overflow)
module edge_bit_packer #(
  parameter int WORD_SIZE  = 8,
  parameter int ROW_SIZE   = 540,
  parameter int NUM_ROWS   = 540,
  parameter int KERNEL_DIM = 3,
  parameter int THRESHOLD  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  edge_bit_packer_if.master bus
);
  localparam int OUT_COLS = ROW_SIZE - KERNEL_DIM + 1;
  localparam int OUT_ROWS = NUM_ROWS - KERNEL_DIM + 1;
  localparam int CW  = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
  localparam int RW  = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
  // column widened to at least 3 bits so the bit position is always a slice
  localparam int CWX = (CW < 3) ? 3 : CW;
  localparam int AW  = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic       sof;
    logic       eol;
    logic       eof;
    logic [7:0] data;
  } ent_t;

  // ---------------- packing ----------------
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [7:0]     sr;
  logic [CWX-1:0] colx;
  logic [2:0]     bpos;
  logic           bit_in, last_col, last_row, done;
  logic [7:0]     cur;
  ent_t           ent_d;

  // completed byte waits one cycle here before entering the FIFO
  logic           push_q;
  ent_t           push_ent;

  assign colx     = CWX'(col);
  assign bpos     = colx[2:0];
  assign bit_in   = (bus.pixel_in >= WORD_SIZE'(THRESHOLD));
  assign last_col = (col == CW'(OUT_COLS - 1));
  assign last_row = (row == RW'(OUT_ROWS - 1));
  // sr holds only bits already placed in this byte, so upper bits of a
  // partial last byte are naturally zero
  assign cur      = sr | ({7'b0, bit_in} << bpos);
  assign done     = bus.pixel_valid && ((bpos == 3'd7) || last_col);

  always_comb begin
    ent_d      = '0;
    ent_d.data = cur;
    ent_d.sof  = (row == '0) && (colx < CWX'(8));
    ent_d.eol  = last_col;
    ent_d.eof  = last_col && last_row;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col      <= '0;
      row      <= '0;
      sr       <= '0;
      push_q   <= 1'b0;
      push_ent <= '0;
    end else begin
      push_q <= done;
      if (done) push_ent <= ent_d;
      if (bus.pixel_valid) begin
        sr <= done ? 8'h00 : cur;
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // ---------------- output FIFO ----------------
  ent_t        mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic        empty, full, pop, push;
  logic        ovf;
  ent_t        head;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = !empty && bus.out_ready;
  // a pop on the same edge frees the slot, so full+pop+push is not a drop
  assign push  = push_q && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= push_ent;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push_q && !push) ovf <= 1'b1;
    end
  end

  assign head = mem[rptr[AW-1:0]];

  // gate with empty so stale storage never shows on the outputs
  assign bus.out_valid = !empty;
  assign bus.out_byte  = empty ? 8'h00 : head.data;
  assign bus.out_sof   = !empty && head.sof;
  assign bus.out_eol   = !empty && head.eol;
  assign bus.out_eof   = !empty && head.eof;
  assign bus.overflow  = ovf;
endmodule

// File: tb/tb_edge_bit_packer.sv
module tb_edge_bit_packer;
  localparam int ROW_SIZE = 12, NUM_ROWS = 5, KERNEL_DIM = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  // captured bytes: {sof, eol, eof, data}
  logic [10:0] capq[$];
  logic [7:0]  row0 [10] = '{8'd100, 8'd0, 8'd100, 8'd0, 8'd100, 8'd0, 8'd100, 8'd63, 8'd64, 8'd0};

  always #5 clk = ~clk;

  edge_bit_packer_if #(.WORD_SIZE(8)) bus ();

  edge_bit_packer #(
    .WORD_SIZE(8), .ROW_SIZE(ROW_SIZE), .NUM_ROWS(NUM_ROWS),
    .KERNEL_DIM(KERNEL_DIM), .THRESHOLD(64), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // a byte is accepted on the next posedge when valid && ready at negedge
  always @(negedge clk)
    if (rst && bus.out_valid && bus.out_ready)
      capq.push_back({bus.out_sof, bus.out_eol, bus.out_eof, bus.out_byte});

  task automatic send(input logic [7:0] p);
    bus.pixel_in    = p;
    bus.pixel_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.pixel_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.pixel_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.pixel_in = 8'hFF;
    bus.pixel_valid = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.overflow !== 1'b0 || bus.out_byte !== 8'h00) begin
        n_err++;
        $display("FAIL reset_outputs: got valid=%b ovf=%b byte=%h, exp 0 0 00", bus.out_valid, bus.overflow, bus.out_byte);
      end
    end
    rst = 1'b1;
    idle(4);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || capq.size() != 0) begin
      n_err++;
      $display("FAIL reset_no_byte: got valid=%b captured=%0d, exp 0 0", bus.out_valid, capq.size());
    end
  endtask

  task automatic test_row();
    capq.delete();
    for (int i = 0; i < 10; i++) begin
      send(row0[i]);
      if (i == 7) begin
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL row_latency_early: got valid=%b, exp 0", bus.out_valid);
        end
      end
      if (i == 8) begin
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_byte !== 8'h55 || bus.out_sof !== 1'b1 || bus.out_eol !== 1'b0) begin
          n_err++;
          $display("FAIL row_latency_head: got valid=%b byte=%h sof=%b eol=%b, exp 1 55 1 0",
                   bus.out_valid, bus.out_byte, bus.out_sof, bus.out_eol);
        end
      end
    end
    idle(4);
    n_cmp++;
    if (capq.size() != 2 || capq[0] !== {3'b100, 8'h55} || capq[1] !== {3'b010, 8'h01}) begin
      n_err++;
      $display("FAIL row_bytes: got n=%0d %h %h, exp n=2 455 201", capq.size(),
               (capq.size() > 0) ? capq[0] : 11'h0, (capq.size() > 1) ? capq[1] : 11'h0);
    end
  endtask

  task automatic test_gapped();
    do_reset();
    capq.delete();
    for (int i = 0; i < 10; i++) begin
      send(row0[i]);
      idle(1);
    end
    idle(4);
    n_cmp++;
    if (capq.size() != 2 || capq[0] !== {3'b100, 8'h55} || capq[1] !== {3'b010, 8'h01}) begin
      n_err++;
      $display("FAIL gapped_bytes: got n=%0d %h %h, exp n=2 455 201", capq.size(),
               (capq.size() > 0) ? capq[0] : 11'h0, (capq.size() > 1) ? capq[1] : 11'h0);
    end
  endtask

  task automatic test_frame();
    logic [10:0] exp [6];
    exp = '{{3'b100, 8'hFF}, {3'b010, 8'h03}, {3'b000, 8'hFF},
            {3'b010, 8'h03}, {3'b000, 8'hFF}, {3'b011, 8'h03}};
    do_reset();
    capq.delete();
    repeat (30) send(8'hFF);
    idle(4);
    n_cmp++;
    if (capq.size() != 6) begin
      n_err++;
      $display("FAIL frame_count: got %0d, exp 6", capq.size());
    end
    for (int i = 0; i < 6; i++) begin
      if (i < capq.size()) begin
        n_cmp++;
        if (capq[i] !== exp[i]) begin
          n_err++;
          $display("FAIL frame_byte%0d: got %h, exp %h", i, capq[i], exp[i]);
        end
      end
    end
    // next frame starts with no idle state
    capq.delete();
    repeat (10) send(8'hFF);
    idle(4);
    n_cmp++;
    if (capq.size() != 2 || capq[0] !== {3'b100, 8'hFF} || capq[1] !== {3'b010, 8'h03}) begin
      n_err++;
      $display("FAIL frame_wrap: got n=%0d %h %h, exp n=2 4ff 203", capq.size(),
               (capq.size() > 0) ? capq[0] : 11'h0, (capq.size() > 1) ? capq[1] : 11'h0);
    end
  endtask

  task automatic test_overflow();
    logic [10:0] exp [4];
    exp = '{{3'b100, 8'hFF}, {3'b010, 8'h03}, {3'b000, 8'hFF}, {3'b010, 8'h03}};
    do_reset();
    capq.delete();
    bus.out_ready = 1'b0;
    repeat (20) send(8'hFF);
    idle(1);
    n_cmp++;
    if (bus.overflow !== 1'b0 || bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_full_no_drop: got ovf=%b valid=%b, exp 0 1", bus.overflow, bus.out_valid);
    end
    repeat (10) send(8'hFF);
    idle(4);
    n_cmp++;
    if (bus.overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_set: got %b, exp 1", bus.overflow);
    end
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_byte !== 8'hFF || bus.out_sof !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_stall_head: got valid=%b byte=%h sof=%b, exp 1 ff 1", bus.out_valid, bus.out_byte, bus.out_sof);
    end
    bus.out_ready = 1'b1;
    idle(8);
    n_cmp++;
    if (capq.size() != 4) begin
      n_err++;
      $display("FAIL ovf_drain_count: got %0d, exp 4", capq.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < capq.size()) begin
        n_cmp++;
        if (capq[i] !== exp[i]) begin
          n_err++;
          $display("FAIL ovf_byte%0d: got %h, exp %h", i, capq[i], exp[i]);
        end
      end
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_after_drain: got valid=%b ovf=%b, exp 0 1", bus.out_valid, bus.overflow);
    end
  endtask

  task automatic test_midframe_reset();
    do_reset();
    repeat (10) send(8'h00);
    repeat (5) send(8'hFF);
    idle(4);
    capq.delete();
    do_reset();
    n_cmp++;
    if (bus.overflow !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_clear: got ovf=%b valid=%b, exp 0 0", bus.overflow, bus.out_valid);
    end
    repeat (10) send(8'hFF);
    idle(4);
    n_cmp++;
    if (capq.size() != 2 || capq[0] !== {3'b100, 8'hFF} || capq[1] !== {3'b010, 8'h03}) begin
      n_err++;
      $display("FAIL midreset_bytes: got n=%0d %h %h, exp n=2 4ff 203", capq.size(),
               (capq.size() > 0) ? capq[0] : 11'h0, (capq.size() > 1) ? capq[1] : 11'h0);
    end
  endtask

  initial begin
    rst             = 1'b0;
    bus.pixel_in    = 8'h00;
    bus.pixel_valid = 1'b0;
    bus.out_ready   = 1'b1;
    test_reset();
    test_row();
    test_gapped();
    test_frame();
    test_overflow();
    test_midframe_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
